// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: 32-cycle shift-add multiplier and restoring divider
// sharing one 64-bit work register, with a single registered write-back port.
module muldiv_unit #(
  parameter bit DIV_EARLY_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd,
  input  logic        flush,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // in_valid while not ready is dropped, never queued.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] a_q, a_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] rs1_q, rs1_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic [31:0] write_data_q, write_data_d;

  logic        s1_in, s2_in, dz_in, ovf_in;
  logic [31:0] m1_in, m2_in;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, div_next;
  logic [31:0] div_shift, div_rem;
  logic        div_ge;

  function automatic logic [31:0] special_result(input logic is_rem, input logic [31:0] f_rs1,
                                                 input logic f_dz);
    if (is_rem) return f_dz ? f_rs1 : 32'h0000_0000;
    else        return f_dz ? 32'hFFFF_FFFF : 32'h8000_0000;
  endfunction

  // Applies operand signs to the magnitude result held in the work register.
  function automatic logic [31:0] final_result(input logic [2:0] f_op, input logic [63:0] f_prod,
                                               input logic f_neg, input logic f_neg_rem);
    logic [63:0] p;
    logic [31:0] r;
    if (!f_op[2]) begin
      p = f_neg ? (~f_prod + 64'd1) : f_prod;
      return (f_op == 3'd0) ? p[31:0] : p[63:32];
    end else if (f_op[1]) begin
      r = f_prod[63:32];
      return f_neg_rem ? (~r + 32'd1) : r;
    end else begin
      r = f_prod[31:0];
      return f_neg ? (~r + 32'd1) : r;
    end
  endfunction

  always_comb begin
    s1_in  = rs1_data[31] && (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6);
    s2_in  = rs2_data[31] && (op == 3'd1 || op == 3'd4 || op == 3'd6);
    m1_in  = s1_in ? (~rs1_data + 32'd1) : rs1_data;
    m2_in  = s2_in ? (~rs2_data + 32'd1) : rs2_data;
    dz_in  = op[2] && (rs2_data == 32'h0);
    ovf_in = op[2] && !op[0] && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
  end

  // Multiply step: add multiplicand into the upper half when the multiplier lsb is set, shift right.
  // Divide step: shift {rem, quotient} left, subtract divisor when it fits.
  always_comb begin
    mul_sum   = {1'b0, prod_q[63:32]} + {1'b0, (prod_q[0] ? a_q : 32'h0)};
    mul_next  = {mul_sum, prod_q[31:1]};
    div_shift = prod_q[62:31];
    div_ge    = prod_q[63] || (div_shift >= a_q);
    div_rem   = div_ge ? (div_shift - a_q) : div_shift;
    div_next  = {div_rem, prod_q[30:0], div_ge};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    rd_d         = rd_q;
    a_d          = a_q;
    prod_d       = prod_q;
    rs1_d        = rs1_q;
    neg_d        = neg_q;
    neg_rem_d    = neg_rem_q;
    dz_d         = dz_q;
    ovf_d        = ovf_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d      = op;
          rd_d      = rd;
          rs1_d     = rs1_data;
          a_d       = op[2] ? m2_in : m1_in;
          prod_d    = {32'h0, (op[2] ? m1_in : m2_in)};
          neg_d     = s1_in ^ s2_in;
          neg_rem_d = s1_in;
          dz_d      = dz_in;
          ovf_d     = ovf_in;
          cnt_d     = 5'd0;
          if (DIV_EARLY_OUT && (dz_in || ovf_in)) begin
            state_d      = DONE;
            reg_write_d  = (rd != 5'd0);
            write_reg_d  = rd;
            write_data_d = special_result(op[1], rs1_data, dz_in);
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 5'd0;
        end else begin
          prod_d = op_q[2] ? div_next : mul_next;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d      = DONE;
            reg_write_d  = (rd_q != 5'd0);
            write_reg_d  = rd_q;
            write_data_d = (dz_q || ovf_q) ? special_result(op_q[1], rs1_q, dz_q)
                                           : final_result(op_q, prod_d, neg_q, neg_rem_q);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 5'd0;
      op_q         <= 3'd0;
      rd_q         <= 5'd0;
      a_q          <= 32'h0;
      prod_q       <= 64'h0;
      rs1_q        <= 32'h0;
      neg_q        <= 1'b0;
      neg_rem_q    <= 1'b0;
      dz_q         <= 1'b0;
      ovf_q        <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      a_q          <= a_d;
      prod_q       <= prod_d;
      rs1_q        <= rs1_d;
      neg_q        <= neg_d;
      neg_rem_q    <= neg_rem_d;
      dz_q         <= dz_d;
      ovf_q        <= ovf_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign in_ready   = (state_q == IDLE) && !flush;
  assign busy       = (state_q != IDLE);
  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: instance a has early-out, instance b iterates every op.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        in_valid_a, in_valid_b;
  logic        in_ready_a, in_ready_b;
  logic [2:0]  op;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd;
  logic        flush;
  logic        reg_write_a, reg_write_b;
  logic [4:0]  write_reg_a, write_reg_b;
  logic [31:0] write_data_a, write_data_b;
  logic        busy_a, busy_b;
  logic [1:0]  dbg_state_a, dbg_state_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [36:0] exp_qa[$];
  logic [36:0] exp_qb[$];
  int          exp_cyc_qa[$];
  int          exp_cyc_qb[$];

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  muldiv_unit #(.DIV_EARLY_OUT(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd), .flush(flush),
    .reg_write(reg_write_a), .write_reg(write_reg_a), .write_data(write_data_a),
    .busy(busy_a), .dbg_state(dbg_state_a)
  );

  muldiv_unit #(.DIV_EARLY_OUT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd), .flush(1'b0),
    .reg_write(reg_write_b), .write_reg(write_reg_b), .write_data(write_data_b),
    .busy(busy_b), .dbg_state(dbg_state_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every reg_write pulse must match the oldest expectation, on its cycle.
  always @(negedge clk) begin
    if (reset && reg_write_a) begin
      if (exp_qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_write: got rd %0d data %h expected no write", write_reg_a, write_data_a);
      end else begin
        check("a_result", {27'h0, write_reg_a, write_data_a}, {27'h0, exp_qa.pop_front()});
        check("a_cycle", 64'(cyc), 64'(exp_cyc_qa.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (reset && reg_write_b) begin
      if (exp_qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_write: got rd %0d data %h expected no write", write_reg_b, write_data_b);
      end else begin
        check("b_result", {27'h0, write_reg_b, write_data_b}, {27'h0, exp_qb.pop_front()});
        check("b_cycle", 64'(cyc), 64'(exp_cyc_qb.pop_front()));
      end
    end
  end

  // reg_write is observed in the cycle that ends at the edge lat cycles after the accept edge.
  task automatic push_exp(input bit sel, input logic [4:0] f_rd, input logic [31:0] exp, input int due);
    if (sel) begin
      exp_qb.push_back({f_rd, exp});
      exp_cyc_qb.push_back(due);
    end else begin
      exp_qa.push_back({f_rd, exp});
      exp_cyc_qa.push_back(due);
    end
  endtask

  // Driver
  task automatic issue(input bit sel, input logic [2:0] f_op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] f_rd, input logic [31:0] exp,
                       input int lat, input bit expect_wr, output int acc);
    int n = 0;
    acc = -1;
    @(negedge clk);
    while (!(sel ? in_ready_b : in_ready_a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("ready_timeout", 64'd0, 64'd1);
      return;
    end
    op = f_op; rs1_data = a; rs2_data = b; rd = f_rd;
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom; rd = 5'($urandom_range(0, 31)); op = 3'($urandom_range(0, 7));
    if (expect_wr && f_rd != 5'd0) push_exp(sel, f_rd, exp, acc + lat - 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_reg_write"}, 64'(reg_write_a), 64'd0);
    check({tag, "_write_reg"}, 64'(write_reg_a), 64'd0);
    check({tag, "_write_data"}, 64'(write_data_a), 64'd0);
    check({tag, "_busy"}, 64'(busy_a), 64'd0);
    check({tag, "_state"}, 64'(dbg_state_a), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready_a), 64'd1);
  endtask

  initial begin
    int acc, a1, run, n;
    reset = 1'b0; flush = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    op = 3'd0; rs1_data = 32'h0; rs2_data = 32'h0; rd = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;

    // Multiplies (iterating, 33-cycle latency)
    issue(0, MUL,    32'd7,        32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, 1, acc);
    issue(0, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 33, 1, acc);
    issue(0, MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 33, 1, acc);
    issue(0, MULHSU, 32'hFFFF_FFFF, 32'd2,        5'd3, 32'hFFFF_FFFF, 33, 1, acc);
    issue(0, MULH,   32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 33, 1, acc);
    issue(0, MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 33, 1, acc);
    issue(0, MULHU,  32'h8000_0000, 32'd4,        5'd7, 32'h0000_0002, 33, 1, acc);

    // Divides: early-out corner cases complete one cycle after accept
    issue(0, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1, 1, acc);
    issue(0, REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h0000_0000, 1, 1, acc);
    issue(0, DIVU, 32'd100,       32'd0,         5'd10, 32'hFFFF_FFFF, 1, 1, acc);
    issue(0, REMU, 32'd100,       32'd0,         5'd11, 32'h0000_0064, 1, 1, acc);
    issue(0, DIV,  32'hFFFF_FFFB, 32'd0,         5'd12, 32'hFFFF_FFFF, 1, 1, acc);
    issue(0, REM,  32'hFFFF_FFFB, 32'd0,         5'd13, 32'hFFFF_FFFB, 1, 1, acc);
    issue(0, DIV,  32'hFFFF_FFF9, 32'd2,         5'd14, 32'hFFFF_FFFD, 33, 1, acc);
    issue(0, REM,  32'hFFFF_FFF9, 32'd2,         5'd15, 32'hFFFF_FFFF, 33, 1, acc);
    issue(0, DIV,  32'd100,       32'hFFFF_FFF9, 5'd16, 32'hFFFF_FFF2, 33, 1, acc);
    issue(0, REM,  32'd100,       32'hFFFF_FFF9, 5'd17, 32'h0000_0002, 33, 1, acc);
    issue(0, DIVU, 32'hFFFF_FFFF, 32'h10,        5'd18, 32'h0FFF_FFFF, 33, 1, acc);
    issue(0, REMU, 32'hFFFF_FFFF, 32'h10,        5'd19, 32'h0000_000F, 33, 1, acc);

    // Same corner cases without early-out iterate the full 33 cycles
    issue(1, DIVU, 32'd100,       32'd0,         5'd20, 32'hFFFF_FFFF, 33, 1, acc);
    issue(1, REMU, 32'd100,       32'd0,         5'd21, 32'h0000_0064, 33, 1, acc);
    issue(1, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, 33, 1, acc);
    issue(1, REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'h0000_0000, 33, 1, acc);
    issue(1, DIV,  32'hFFFF_FFF9, 32'd2,         5'd24, 32'hFFFF_FFFD, 33, 1, acc);

    // rd=0 op with in_valid held high: busy 33 cycles, next op accepted one cycle after DONE
    n = 0;
    @(negedge clk);
    while (!in_ready_a && n < 200) begin @(negedge clk); n++; end
    op = MUL; rs1_data = 32'd3; rs2_data = 32'd5; rd = 5'd0; in_valid_a = 1'b1;
    @(posedge clk);
    #1;
    a1 = cyc;
    rs1_data = 32'd6; rs2_data = 32'd7; rd = 5'd6;
    push_exp(0, 5'd6, 32'd42, a1 + 34 + 32);
    run = 0;
    @(negedge clk);
    while (busy_a && run < 100) begin
      run++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(run), 64'd33);
    check("b2b_ready", 64'(in_ready_a), 64'd1);
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    @(negedge clk);
    check("b2b_busy", 64'(busy_a), 64'd1);

    // Flush at CALC cycle 10 abandons the op and blocks accept while held
    issue(0, MUL, 32'd5, 32'd5, 5'd25, 32'd0, 33, 0, acc);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_state", 64'(dbg_state_a), 64'd0);
    check("flush_busy", 64'(busy_a), 64'd0);
    check("flush_in_ready", 64'(in_ready_a), 64'd0);
    @(negedge clk);
    op = MUL; rs1_data = 32'd2; rs2_data = 32'd2; rd = 5'd3; in_valid_a = 1'b1;
    @(posedge clk);
    #1;
    check("flush_blocks_accept", 64'(busy_a), 64'd0);
    in_valid_a = 1'b0;
    flush = 1'b0;
    #1;
    check("flush_release_ready", 64'(in_ready_a), 64'd1);

    // Reset at CALC cycle 20 discards the op; first edge after release accepts
    issue(0, DIVU, 32'd1000, 32'd3, 5'd26, 32'd0, 33, 0, acc);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("midcalc_reset");
    @(negedge clk);
    reset = 1'b1;
    op = DIVU; rs1_data = 32'd1000; rs2_data = 32'd3; rd = 5'd27; in_valid_a = 1'b1;
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    check("post_reset_accept", 64'(busy_a), 64'd1);
    push_exp(0, 5'd27, 32'h0000_014D, cyc + 32);

    // Drain the scoreboard
    n = 0;
    while ((exp_qa.size() != 0 || exp_qb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_a", 64'(exp_qa.size()), 64'd0);
    check("drain_b", 64'(exp_qb.size()), 64'd0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
